rotary_encoder_multi: RTL and testbench

//  N-channel quadrature rotary-encoder front end: synchronises and debounces raw A/B/switch pins,

---
 rtl/rotary_encoder_multi_pkg.sv | 27 ++
 rtl/rotary_encoder_multi_channel.sv | 144 ++++++++++++++
 rtl/rotary_encoder_multi.sv | 56 +++++
 tb/tb_rotary_encoder_multi.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rotary_encoder_multi_pkg.sv
// Shared definitions for the multi-channel quadrature encoder front end:
// detent rest encoding, step direction codes and the Gray-code step decoder.
package rotary_encoder_multi_pkg;

  localparam logic [1:0] AB_REST = 2'b11;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2,
    DIR_ERR  = 2'd3
  } dir_t;

  // {prev, cur} are {A, B} pairs; a simultaneous change of both bits is illegal.
  function automatic dir_t quad_dir(input logic [1:0] prev, input logic [1:0] cur);
    dir_t d;
    d = DIR_NONE;
    case ({prev, cur})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: d = DIR_UP;
      4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: d = DIR_DOWN;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: d = DIR_ERR;
      default:                                d = DIR_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rotary_encoder_multi_channel.sv
// One encoder channel: pin synchronisers, three debouncers, Gray decoder,
// detent accumulator, position counter and push-switch edge detect.
module rotary_encoder_multi_channel
  import rotary_encoder_multi_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_CYC  = 50000,
  parameter int STEPS_PER_DET = 4,
  parameter int WRAP          = 0,
  parameter int BTN_ACT_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_a,
  input  logic                    in_b,
  input  logic                    switch,
  input  logic                    clear,
  output logic                    up,
  output logic                    down,
  output logic                    button,
  output logic                    btn_press,
  output logic                    quad_err,
  output logic signed [CNT_W-1:0] position
);

  localparam int ACC_W = 4;
  localparam logic [2:0] RST_VAL = {(BTN_ACT_LOW != 0), 1'b1, 1'b1};
  localparam logic signed [ACC_W-1:0] ACC_TOP = ACC_W'(STEPS_PER_DET - 1);
  localparam logic signed [CNT_W-1:0] POS_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] POS_MIN = {1'b1, {(CNT_W-1){1'b0}}};

  // bit 0 = A, bit 1 = B, bit 2 = switch
  logic [2:0] raw;
  logic [2:0] synced;
  logic [2:0] deb;

  assign raw = {switch, in_b, in_a};

  for (genvar s = 0; s < 3; s++) begin : g_sig
    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff <= {SYNC_STAGES{RST_VAL[s]}};
      else        ff <= {ff[SYNC_STAGES-2:0], raw[s]};
    end

    assign synced[s] = ff[SYNC_STAGES-1];

    if (DEBOUNCE_CYC == 0) begin : g_bypass
      assign deb[s] = synced[s];
    end else begin : g_deb
      localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
      logic [CW-1:0] cnt;
      logic          deb_q;

      // Counts consecutive cycles of disagreement; any agreement restarts it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt   <= '0;
          deb_q <= RST_VAL[s];
        end else if (synced[s] == deb_q) begin
          cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
          cnt   <= '0;
          deb_q <= synced[s];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      assign deb[s] = deb_q;
    end
  end

  logic [1:0]             ab;
  logic [1:0]             prev_ab;
  dir_t                   step;
  logic signed [ACC_W-1:0] acc;
  logic signed [CNT_W-1:0] pos_inc;
  logic signed [CNT_W-1:0] pos_dec;

  assign ab   = {deb[0], deb[1]};
  assign step = quad_dir(prev_ab, ab);

  always_comb begin
    pos_inc = position + CNT_W'(1);
    pos_dec = position - CNT_W'(1);
    if (WRAP == 0 && position == POS_MAX) pos_inc = position;
    if (WRAP == 0 && position == POS_MIN) pos_dec = position;
  end

  // clear wins over a completing step: the step is dropped with no pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_ab  <= AB_REST;
      acc      <= '0;
      position <= '0;
      up       <= 1'b0;
      down     <= 1'b0;
      quad_err <= 1'b0;
    end else begin
      prev_ab  <= ab;
      up       <= 1'b0;
      down     <= 1'b0;
      quad_err <= (step == DIR_ERR);
      if (clear) begin
        acc      <= '0;
        position <= '0;
      end else if (step == DIR_UP) begin
        if (acc == ACC_TOP) begin
          acc      <= '0;
          up       <= 1'b1;
          position <= pos_inc;
        end else begin
          acc <= acc + ACC_W'(1);
        end
      end else if (step == DIR_DOWN) begin
        if (acc == -ACC_TOP) begin
          acc      <= '0;
          down     <= 1'b1;
          position <= pos_dec;
        end else begin
          acc <= acc - ACC_W'(1);
        end
      end
    end
  end

  logic btn_prev;

  assign button = deb[2] ^ (BTN_ACT_LOW != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev  <= 1'b0;
      btn_press <= 1'b0;
    end else begin
      btn_prev  <= button;
      btn_press <= button & ~btn_prev;
    end
  end

endmodule

// File: rtl/rotary_encoder_multi.sv
// N-channel rotary encoder front end; each channel is an independent
// rotary_encoder_multi_channel and positions are packed channel-major.
module rotary_encoder_multi
  import rotary_encoder_multi_pkg::*;
#(
  parameter int N_CH          = 2,
  parameter int CNT_W         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_CYC  = 50000,
  parameter int STEPS_PER_DET = 4,
  parameter int WRAP          = 0,
  parameter int BTN_ACT_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         in_a,
  input  logic [N_CH-1:0]         in_b,
  input  logic [N_CH-1:0]         switch,
  input  logic [N_CH-1:0]         clear,
  output logic [N_CH-1:0]         up,
  output logic [N_CH-1:0]         down,
  output logic [N_CH-1:0]         button,
  output logic [N_CH-1:0]         btn_press,
  output logic [N_CH-1:0]         quad_err,
  output logic [N_CH*CNT_W-1:0]   position
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic signed [CNT_W-1:0] pos;

    rotary_encoder_multi_channel #(
      .CNT_W        (CNT_W),
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .STEPS_PER_DET(STEPS_PER_DET),
      .WRAP         (WRAP),
      .BTN_ACT_LOW  (BTN_ACT_LOW)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_a     (in_a[i]),
      .in_b     (in_b[i]),
      .switch   (switch[i]),
      .clear    (clear[i]),
      .up       (up[i]),
      .down     (down[i]),
      .button   (button[i]),
      .btn_press(btn_press[i]),
      .quad_err (quad_err[i]),
      .position (pos)
    );

    assign position[i*CNT_W +: CNT_W] = pos;
  end

endmodule

// File: tb/tb_rotary_encoder_multi.sv
// Directed bench for rotary_encoder_multi: a saturating and a wrapping instance
// share stimulus; pulse events are matched in order against an expected queue.
module tb_rotary_encoder_multi;

  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  in_a, in_b, switch, clear;
  logic [1:0]  up, down, button, btn_press, quad_err;
  logic [15:0] position;
  logic [1:0]  w_up, w_down, w_button, w_btn_press, w_quad_err;
  logic [15:0] w_position;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_up0_cyc = 0;
  int up0_count = 0;
  int btn_hi0 = 0;
  int btn_hi1 = 0;

  // event code = {channel, kind}; kind 0 up, 1 down, 2 quad_err, 3 btn_press
  logic [2:0] exp_q[$];

  rotary_encoder_multi #(
    .N_CH(2), .CNT_W(8), .SYNC_STAGES(2), .DEBOUNCE_CYC(4),
    .STEPS_PER_DET(4), .WRAP(0), .BTN_ACT_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .switch(switch),
    .clear(clear), .up(up), .down(down), .button(button),
    .btn_press(btn_press), .quad_err(quad_err), .position(position)
  );

  rotary_encoder_multi #(
    .N_CH(2), .CNT_W(8), .SYNC_STAGES(2), .DEBOUNCE_CYC(4),
    .STEPS_PER_DET(4), .WRAP(1), .BTN_ACT_LOW(1)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .switch(switch),
    .clear(clear), .up(w_up), .down(w_down), .button(w_button),
    .btn_press(w_btn_press), .quad_err(w_quad_err), .position(w_position)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every pulse seen must be the next expected event.
  always @(negedge clk) begin
    logic       pulse;
    logic [2:0] code;
    logic [2:0] e;
    if (rst_n) begin
      if (up[0]) begin
        last_up0_cyc = cyc;
        up0_count++;
      end
      if (button[0]) btn_hi0++;
      if (button[1]) btn_hi1++;
      for (int ch = 0; ch < 2; ch++) begin
        for (int t = 0; t < 4; t++) begin
          case (t)
            0:       pulse = up[ch];
            1:       pulse = down[ch];
            2:       pulse = quad_err[ch];
            default: pulse = btn_press[ch];
          endcase
          if (pulse) begin
            code = 3'(ch * 4 + t);
            if (exp_q.size() == 0) begin
              check("unexpected_pulse", {29'd0, code}, 32'hFF);
            end else begin
              e = exp_q.pop_front();
              check("pulse_event", {29'd0, code}, {29'd0, e});
            end
          end
        end
      end
    end
  end

  task automatic set_ab(input int ch, input logic [1:0] ab, input int hold);
    in_a[ch] = ab[1];
    in_b[ch] = ab[0];
    repeat (hold) @(negedge clk);
  endtask

  task automatic detent_cw(input int ch);
    set_ab(ch, 2'b01, HOLD);
    set_ab(ch, 2'b00, HOLD);
    set_ab(ch, 2'b10, HOLD);
    exp_q.push_back(3'(ch * 4));
    set_ab(ch, 2'b11, HOLD);
  endtask

  task automatic detent_ccw(input int ch);
    set_ab(ch, 2'b10, HOLD);
    set_ab(ch, 2'b00, HOLD);
    set_ab(ch, 2'b01, HOLD);
    exp_q.push_back(3'(ch * 4 + 1));
    set_ab(ch, 2'b11, HOLD);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (12) @(negedge clk);
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int u;
    int b;
    in_a = 2'b11; in_b = 2'b11; switch = 2'b11; clear = 2'b00; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_up", up, 0);
    check("rst_down", down, 0);
    check("rst_qerr", quad_err, 0);
    check("rst_press", btn_press, 0);
    check("rst_button", button, 0);
    check("rst_position", position, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_position", position, 0);
    check("idle_button", button, 0);

    // 1: one clockwise detent on ch0, latency from final edge
    set_ab(0, 2'b01, 10);
    set_ab(0, 2'b00, 10);
    set_ab(0, 2'b10, 10);
    exp_q.push_back(3'd0);
    t0 = cyc;
    set_ab(0, 2'b11, 12);
    check("t1_latency", last_up0_cyc - t0, 7);
    check("t1_up_count", up0_count, 1);
    drain("t1_drain");
    check("t1_pos0", position[7:0], 8'd1);
    check("t1_pos1", position[15:8], 8'd0);
    check("t1_button1", button[1], 0);

    // 2: three CCW detents on ch1, then a half detent and back
    repeat (3) detent_ccw(1);
    drain("t2_drain");
    check("t2_pos1", position[15:8], 8'hFD);
    set_ab(1, 2'b10, HOLD);
    set_ab(1, 2'b00, HOLD);
    set_ab(1, 2'b10, HOLD);
    set_ab(1, 2'b11, HOLD);
    drain("t2_half_drain");
    check("t2_half_pos1", position[15:8], 8'hFD);

    // 3: short glitch on A and switch of ch0
    b = btn_hi0;
    in_a[0] = 1'b0; switch[0] = 1'b0;
    repeat (3) @(negedge clk);
    in_a[0] = 1'b1; switch[0] = 1'b1;
    repeat (20) @(negedge clk);
    drain("t3_no_events");
    check("t3_button_cycles", btn_hi0 - b, 0);
    check("t3_pos0", position[7:0], 8'd1);

    // 4: saturation vs wrap over 130 detents
    clear = 2'b11;
    @(negedge clk);
    clear = 2'b00;
    @(negedge clk);
    check("t4_clear_pos", position, 0);
    check("t4_clear_wpos", w_position, 0);
    u = up0_count;
    for (int i = 0; i < 130; i++) detent_cw(0);
    drain("t4_drain");
    check("t4_up_count", up0_count - u, 130);
    check("t4_sat_pos", position[7:0], 8'h7F);
    check("t4_wrap_pos", w_position[7:0], 8'h82);

    // 5: illegal double transition, then clear colliding with a detent
    exp_q.push_back(3'd2);
    set_ab(0, 2'b00, HOLD + 4);
    drain("t5_qerr");
    check("t5_pos_after_err", position[7:0], 8'h7F);
    set_ab(0, 2'b10, HOLD);
    set_ab(0, 2'b11, HOLD);
    clear[0] = 1'b1;
    @(negedge clk);
    clear[0] = 1'b0;
    @(negedge clk);
    check("t5_clear_pos", position[7:0], 8'd0);
    detent_cw(0);
    drain("t5_detent");
    check("t5_pos_one", position[7:0], 8'd1);
    set_ab(0, 2'b01, HOLD);
    set_ab(0, 2'b00, HOLD);
    set_ab(0, 2'b10, HOLD);
    in_a[0] = 1'b1; in_b[0] = 1'b1;
    repeat (6) @(negedge clk);
    clear[0] = 1'b1;
    @(negedge clk);
    clear[0] = 1'b0;
    repeat (10) @(negedge clk);
    drain("t5_clear_no_up");
    check("t5_clear_wins_pos", position[7:0], 8'd0);

    // 6: button press on ch1
    b = btn_hi1;
    exp_q.push_back(3'd7);
    switch[1] = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_button_held", button[1], 1);
    switch[1] = 1'b1;
    repeat (12) @(negedge clk);
    check("t6_button_released", button[1], 0);
    drain("t6_press");
    check("t6_button_cycles", btn_hi1 - b, 10);

    // 6: reset mid-detent
    set_ab(0, 2'b01, HOLD);
    rst_n = 1'b0;
    #1;
    check("t6_rst_up", up, 0);
    check("t6_rst_down", down, 0);
    check("t6_rst_qerr", quad_err, 0);
    check("t6_rst_press", btn_press, 0);
    check("t6_rst_button", button, 0);
    check("t6_rst_position", position, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    set_ab(0, 2'b11, HOLD);
    drain("t6_no_spurious");
    check("t6_pos_after_rst", position[7:0], 8'd0);
    detent_cw(0);
    drain("t6_new_detent");
    check("t6_pos_new_detent", position[7:0], 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
